// File: rtl/button_counter_pkg.sv
// Shared constants and helpers for the button front-end.
// Counter width, 12 MHz debounce default, clog2.
package button_counter_pkg;

  localparam int CNT_W = 8;
  localparam int DEB_12MHZ = 120000;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, debouncer and press pulse for one button.
// Ports: clk, rst (sync, active high), raw in; level, press out.
module button_debounce
  import button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_12MHZ,
  parameter bit ACTIVE_HIGH     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  // raw level of a released button
  localparam logic IDLE = ACTIVE_HIGH ? 1'b0 : 1'b1;

  logic          s1;
  logic          s2;
  logic          sp;
  logic          lvl;
  logic          hit;
  logic [CW-1:0] cnt;

  assign sp    = ACTIVE_HIGH ? s2 : ~s2;
  assign hit   = (cnt == CMAX);
  assign level = lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= IDLE;
      s2    <= IDLE;
      lvl   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      // fires on the same edge lvl rises
      press <= sp & ~lvl & hit;
      if (sp == lvl) begin
        cnt <= '0;
      end else if (hit) begin
        lvl <= sp;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_counter.sv
// Up/down counter driven by two debounced buttons, shown on LEDs.
// Ports: clk, rst, sw1, sw2 in; sw1_press, sw2_press, count, leds out.
module button_counter
  import button_counter_pkg::*;
#(
  parameter int               DEBOUNCE_CYCLES = DEB_12MHZ,
  parameter bit               ACTIVE_HIGH     = 1'b1,
  parameter logic [CNT_W-1:0] INIT_COUNT      = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw1,
  input  logic             sw2,
  output logic             sw1_press,
  output logic             sw2_press,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] leds
);

  logic lvl1;
  logic lvl2;
  logic unused_lvl;

  assign unused_lvl = lvl1 ^ lvl2;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_HIGH    (ACTIVE_HIGH)
  ) u_sw1 (
    .clk  (clk),
    .rst  (rst),
    .raw  (sw1),
    .level(lvl1),
    .press(sw1_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_HIGH    (ACTIVE_HIGH)
  ) u_sw2 (
    .clk  (clk),
    .rst  (rst),
    .raw  (sw2),
    .level(lvl2),
    .press(sw2_press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= INIT_COUNT;
    end else begin
      unique case ({sw1_press, sw2_press})
        2'b10:   count <= count + 8'd1;
        2'b01:   count <= count - 8'd1;
        default: count <= count;
      endcase
    end
  end

  // LEDn shows count[n]; LED0 sits on leds[7]
  for (genvar i = 0; i < CNT_W; i++) begin : g_led
    assign leds[CNT_W-1-i] = count[i];
  end

endmodule

// File: tb/tb_button_counter.sv
// Scoreboard bench for button_counter, three instances (INIT 00/FF/A5).
// Stimulus queues expected pulses; per-instance monitors pop and compare.
module tb_button_counter;

  localparam int N  = 3;
  localparam int DC = 4;

  typedef struct {
    logic       a;
    logic       b;
    int         cyc;
    logic [7:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst [N];
  logic       sw1 [N];
  logic       sw2 [N];
  logic       p1  [N];
  logic       p2  [N];
  logic [7:0] cnt [N];
  logic [7:0] leds[N];

  exp_t q[N][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_of(input int i);
    if (i == 0) return 8'h00;
    if (i == 1) return 8'hFF;
    return 8'hA5;
  endfunction

  function automatic logic [7:0] rev(input logic [7:0] v);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[7-j] = v[j];
    return r;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h cyc %0d",
               nm, i, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  for (genvar g = 0; g < N; g++) begin : u
    localparam logic [7:0] IV =
      (g == 0) ? 8'h00 : (g == 1) ? 8'hFF : 8'hA5;

    button_counter #(
      .DEBOUNCE_CYCLES(DC),
      .ACTIVE_HIGH    (1'b1),
      .INIT_COUNT     (IV)
    ) dut (
      .clk      (clk),
      .rst      (rst[g]),
      .sw1      (sw1[g]),
      .sw2      (sw2[g]),
      .sw1_press(p1[g]),
      .sw2_press(p2[g]),
      .count    (cnt[g]),
      .leds     (leds[g])
    );

    bit   pend = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
      if (pend) begin
        chk("count_after", g, 32'(cnt[g]), 32'(cur.c));
        chk("leds_after", g, 32'(leds[g]), 32'(rev(cur.c)));
        pend = 1'b0;
      end
      if (p1[g] || p2[g]) begin
        if (q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse[%0d] got sw1=%0b sw2=%0b expected none cyc %0d",
                   g, p1[g], p2[g], cyc);
        end else begin
          cur = q[g].pop_front();
          chk("pulse_cyc", g, 32'(cyc), 32'(cur.cyc));
          chk("sw1_press", g, 32'(p1[g]), 32'(cur.a));
          chk("sw2_press", g, 32'(p2[g]), 32'(cur.b));
          pend = 1'b1;
        end
      end
    end
  end

  task automatic press(input int i, input logic a, input logic b,
                       input logic [7:0] c);
    int k;
    k = cyc + 1;
    sw1[i] = a;
    sw2[i] = b;
    q[i].push_back('{a: a, b: b, cyc: k + DC + 1, c: c});
    tick(12);
    sw1[i] = 1'b0;
    sw2[i] = 1'b0;
    tick(10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      sw1[i] = 1'b0;
      sw2[i] = 1'b0;
    end
    tick(3);
    for (int i = 0; i < N; i++) begin
      chk("rst_count", i, 32'(cnt[i]), 32'(init_of(i)));
      chk("rst_leds", i, 32'(leds[i]), 32'(rev(init_of(i))));
      chk("rst_sw1_press", i, 32'(p1[i]), 32'd0);
      chk("rst_sw2_press", i, 32'(p2[i]), 32'd0);
      rst[i] = 1'b0;
    end
    tick(2);

    // clean press, held 20 cycles
    k = cyc + 1;
    sw1[0] = 1'b1;
    q[0].push_back('{a: 1'b1, b: 1'b0, cyc: k + 5, c: 8'h01});
    tick(20);
    chk("held_count", 0, 32'(cnt[0]), 32'h01);
    sw1[0] = 1'b0;
    tick(10);

    // bounce 1,0,1,0 then stable 1 from edge k+4
    k = cyc + 1;
    sw1[0] = 1'b1; tick(1);
    sw1[0] = 1'b0; tick(1);
    sw1[0] = 1'b1; tick(1);
    sw1[0] = 1'b0; tick(1);
    sw1[0] = 1'b1;
    q[0].push_back('{a: 1'b1, b: 1'b0, cyc: k + 9, c: 8'h02});
    tick(15);
    chk("bounce_count", 0, 32'(cnt[0]), 32'h02);
    sw1[0] = 1'b0;
    tick(10);

    // both buttons in the same cycle: count holds
    press(0, 1'b1, 1'b1, 8'h02);

    // wrap on the FF instance
    press(1, 1'b1, 1'b0, 8'h00);
    press(1, 1'b0, 1'b1, 8'hFF);
    press(1, 1'b0, 1'b1, 8'hFE);

    // reset two cycles into a sw2 debounce, sw2 kept held
    sw2[0] = 1'b1;
    tick(2);
    rst[0] = 1'b1;
    k = cyc + 1;
    q[0].push_back('{a: 1'b0, b: 1'b1, cyc: k + DC + 2, c: 8'hFF});
    tick(1);
    rst[0] = 1'b0;
    chk("midrst_count", 0, 32'(cnt[0]), 32'h00);
    tick(14);
    sw2[0] = 1'b0;
    tick(10);

    chk("final_count", 0, 32'(cnt[0]), 32'hFF);
    chk("final_count", 1, 32'(cnt[1]), 32'hFE);
    chk("final_count", 2, 32'(cnt[2]), 32'hA5);
    chk("final_leds", 2, 32'(leds[2]), 32'(rev(8'hA5)));
    for (int i = 0; i < N; i++)
      chk("missing_pulses", i, 32'(q[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
